// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, frame
// field widths, default sizing and the running checksum helper.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W      = 8;
    localparam int IMEM_TIMEOUT_CYC = 100000;
    localparam int LEN_W            = 16;
    localparam int BYTE_W           = 8;
    localparam int WORD_W           = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } ld_state_e;

    function automatic logic [BYTE_W-1:0] csum_next(
        input logic [BYTE_W-1:0] acc,
        input logic [BYTE_W-1:0] data
    );
        csum_next = acc ^ data;
    endfunction

    // States in which the loader takes bytes from the link and a load is live
    function automatic logic is_rx_state(input ld_state_e st);
        is_rx_state = (st == ST_LEN0) || (st == ST_LEN1) ||
                      (st == ST_DATA) || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word packer: the first byte of a word lands in bits
// [7:0]; a registered one-cycle word_valid follows the fourth byte.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              last_byte,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        cnt_r;
    logic [23:0]       sh_r;
    logic              word_valid_r;
    logic [WORD_W-1:0] word_r;

    assign last_byte  = (cnt_r == 2'd3);
    assign word_valid = word_valid_r;
    assign word       = word_r;

    // Shift bytes in and publish the completed word; word_r holds between words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= 2'd0;
            sh_r         <= 24'd0;
            word_valid_r <= 1'b0;
            word_r       <= 32'd0;
        end else begin
            word_valid_r <= 1'b0;
            if (clr) begin
                cnt_r <= 2'd0;
                sh_r  <= 24'd0;
            end else if (byte_valid) begin
                cnt_r <= cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    word_r       <= {byte_in, sh_r};
                    word_valid_r <= 1'b1;
                end else begin
                    sh_r <= {byte_in, sh_r[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame-driven instruction memory loader: parses LEN/DATA/CSUM from a byte
// stream, writes words to imem and holds the core while a load is live.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int TIMEOUT_CYC = IMEM_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int                TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(2 ** ADDR_W);
    localparam logic [TMO_W-1:0]  TMO_END = TMO_W'(TIMEOUT_CYC - 1);

    ld_state_e         state_r;
    ld_state_e         state_s;
    logic              rx_ready_r;
    logic              busy_r;
    logic              cpu_hold_r;
    logic              done_r;
    logic              error_r;
    logic [BYTE_W-1:0] len_lo_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  word_cnt_r;
    logic [BYTE_W-1:0] csum_r;
    logic [TMO_W-1:0]  tmo_r;
    logic [ADDR_W-1:0] waddr_r;

    logic              accept_s;
    logic              start_go_s;
    logic              tmo_hit_s;
    logic [LEN_W-1:0]  len_s;
    logic              asm_valid_s;
    logic              last_byte_s;
    logic              last_word_s;

    assign accept_s    = rx_valid && rx_ready_r;
    assign start_go_s  = start && ((state_r == ST_IDLE) || (state_r == ST_ERR));
    assign tmo_hit_s   = busy_r && !accept_s && (tmo_r == TMO_END);
    assign len_s       = {rx_data, len_lo_r};
    assign asm_valid_s = accept_s && (state_r == ST_DATA);
    assign last_word_s = last_byte_s && ((word_cnt_r + 16'd1) == len_r);

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_go_s),
        .byte_valid (asm_valid_s),
        .byte_in    (rx_data),
        .last_byte  (last_byte_s),
        .word_valid (mem_we),
        .word       (mem_wdata)
    );

    // Next-state decode; an accepted byte takes priority over an expiring timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_LEN0;
                else       state_s = ST_IDLE;
            end
            ST_LEN0: begin
                if (accept_s)       state_s = ST_LEN1;
                else if (tmo_hit_s) state_s = ST_ERR;
                else                state_s = ST_LEN0;
            end
            ST_LEN1: begin
                if (accept_s) begin
                    if (len_s == 16'd0)       state_s = ST_CSUM;
                    else if (len_s > LEN_MAX) state_s = ST_ERR;
                    else                      state_s = ST_DATA;
                end else if (tmo_hit_s) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_LEN1;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    if (last_word_s) state_s = ST_CSUM;
                    else             state_s = ST_DATA;
                end else if (tmo_hit_s) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (rx_data == csum_r) state_s = ST_DONE;
                    else                   state_s = ST_ERR;
                end else if (tmo_hit_s) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_CSUM;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR: begin
                if (start) state_s = ST_LEN0;
                else       state_s = ST_ERR;
            end
            // An illegal encoding keeps the core held until the host restarts
            default: state_s = ST_ERR;
        endcase
    end

    // State register and status outputs, all decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            cpu_hold_r <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            rx_ready_r <= is_rx_state(state_s);
            busy_r     <= is_rx_state(state_s);
            cpu_hold_r <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r     <= (state_s == ST_DONE);
            error_r    <= (state_s == ST_ERR);
        end
    end

    // Frame datapath: length capture, running checksum, word index, idle timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_r   <= 8'd0;
            len_r      <= 16'd0;
            word_cnt_r <= 16'd0;
            csum_r     <= 8'd0;
            tmo_r      <= '0;
            waddr_r    <= '0;
        end else if (start_go_s) begin
            word_cnt_r <= 16'd0;
            csum_r     <= 8'd0;
            tmo_r      <= '0;
        end else if (accept_s) begin
            csum_r <= csum_next(csum_r, rx_data);
            tmo_r  <= '0;
            if (state_r == ST_LEN0) begin
                len_lo_r <= rx_data;
            end
            if (state_r == ST_LEN1) begin
                len_r <= len_s;
            end
            // Address is latched alongside the word so it is valid with mem_we
            if ((state_r == ST_DATA) && last_byte_s) begin
                waddr_r    <= word_cnt_r[ADDR_W-1:0];
                word_cnt_r <= word_cnt_r + 16'd1;
            end
        end else if (busy_r) begin
            tmo_r <= tmo_r + TMO_W'(1);
        end
    end

    assign rx_ready  = rx_ready_r;
    assign busy      = busy_r;
    assign cpu_hold  = cpu_hold_r;
    assign done      = done_r;
    assign error     = error_r;
    assign mem_waddr = waddr_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected imem writes go to a scoreboard
// queue when a frame is sent and are popped as mem_we pulses appear.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    int          tests_run = 0;
    int          fails = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  frame1 [0:10];

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (mem_we) begin
            logic [39:0] e;
            we_cnt++;
            tests_run++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_we: observed addr %h data %h expected no write",
                       mem_waddr, mem_wdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("we_addr", 32'(mem_waddr), {24'd0, e[39:32]});
                chk("we_data", mem_wdata, e[31:0]);
            end
        end
        if (done) done_cnt++;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("byte_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
        chk({tag, "_waddr"},    32'(mem_waddr),    32'd0);
        chk({tag, "_wdata"},    mem_wdata,         32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_error"},    {31'd0, error},    32'd0);
    endtask

    task automatic run_frame1(input string tag);
        int d0;
        d0 = done_cnt;
        pulse_start();
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
        exp_q.push_back({8'h00, 32'h12345678});
        exp_q.push_back({8'h01, 32'hDEADBEEF});
        for (int i = 0; i < 11; i++) send_byte(frame1[i]);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {31'd0, error}, 32'd0);
        chk({tag, "_hold_rel"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        chk({tag, "_done_cnt"}, done_cnt - d0, 32'd1);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we0;
        int d0;
        frame1 = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};

        #23;
        chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // 1: good two-word frame
        run_frame1("t1");

        // 2: same frame, wrong checksum
        d0 = done_cnt;
        pulse_start();
        exp_q.push_back({8'h00, 32'h12345678});
        exp_q.push_back({8'h01, 32'hDEADBEEF});
        for (int i = 0; i < 10; i++) send_byte(frame1[i]);
        send_byte(8'h29);
        chk("t2_error", {31'd0, error}, 32'd1);
        chk("t2_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        chk("t2_drained", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        chk("t2_no_done", done_cnt - d0, 32'd0);
        chk("t2_sticky", {31'd0, error}, 32'd1);
        pulse_start();
        chk("t2_err_clr", {31'd0, error}, 32'd0);

        // 3: oversize length (257) aborts right after LEN1
        we0 = we_cnt;
        send_byte(8'h01);
        send_byte(8'h01);
        chk("t3_error", {31'd0, error}, 32'd1);
        chk("t3_ready", {31'd0, rx_ready}, 32'd0);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_ready_hold", {31'd0, rx_ready}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        rx_valid = 1'b0;
        chk("t3_no_we", we_cnt - we0, 32'd0);

        // 4: zero-length frame
        we0 = we_cnt;
        d0  = done_cnt;
        pulse_start();
        chk("t4_err_clr", {31'd0, error}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_hold", {31'd0, cpu_hold}, 32'd0);
        @(posedge clk); #1;
        chk("t4_no_we", we_cnt - we0, 32'd0);
        chk("t4_done_cnt", done_cnt - d0, 32'd1);

        // 5: idle timeout with a partial word pending
        we0 = we_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        repeat (15) @(posedge clk);
        #1;
        chk("t5_no_err_yet", {31'd0, error}, 32'd0);
        chk("t5_still_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("t5_timeout_err", {31'd0, error}, 32'd1);
        chk("t5_hold", {31'd0, cpu_hold}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_we", we_cnt - we0, 32'd0);

        // 6: reset mid-DATA, then a clean reload
        we0 = we_cnt;
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 rx_valid = ~rx_valid;
            rx_data = 8'h34;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("t6_post");
        chk("t6_no_we", we_cnt - we0, 32'd0);
        run_frame1("t6_reload");

        chk("final_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
